// File: rtl/lib_cpu_pkg.sv
// CPU-wide datapath types shared between pipeline stages.
// Struct widths are fixed at the default 32-bit datapath and 64-word data RAM.
package lib_cpu;

    localparam int CPU_XLEN   = 32;
    localparam int CPU_MEM_AW = 6;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic                intr_en;
        logic [CPU_XLEN-1:0] intr_vec;
        logic [CPU_XLEN-1:0] intr_pc;
        logic                ack;
        logic                tx_req;
        logic [7:0]          tx_data;
    } SPECIAL_REG;

    typedef struct packed {
        logic                  w_rd;
        logic [CPU_XLEN-1:0]   x_rd;
        logic                  mem_r_req;
        logic                  mem_w_req;
        logic [CPU_MEM_AW-1:0] mem_addr;
        SPECIAL_REG            sr;
    } EXECUTE;

endpackage

// File: rtl/lib_mem_pkg.sv
// Memory/writeback stage definitions: FSM states, RAM depth, SR reset value.
package lib_mem;

    import lib_cpu::*;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } MEM_STATE;

    localparam int MEM_WORDS = 64;

    localparam SPECIAL_REG SR_RESET = '0;

endpackage

// File: rtl/lib_data_ram.sv
// Single-port data RAM, synchronous write, registered read (read-before-write).
// Latency: read data valid one cycle after the read enable edge.
// Backpressure: none; accepts an access every cycle.
module lib_data_ram #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/lib_mem_wb.sv
// Memory/writeback stage: data RAM access, register-file write, SR commit, interrupt latch.
// Latency: commit 1 cycle after accept (2 for loads); sr updates on the edge ending commit.
// Backpressure: ex_ready only in S_IDLE, so one instruction in flight at a time.
module lib_mem_wb
    import lib_cpu::*;
    import lib_mem::*;
#(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 6,
    parameter int RF_AW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  EXECUTE           ex,
    input  logic [RF_AW-1:0] ex_rd,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output SPECIAL_REG       sr,
    output logic             commit,
    input  logic             intr_req,
    output logic             intr_pending
);

    MEM_STATE    state;
    logic        hold_we;
    SPECIAL_REG  hold_sr;
    logic        accept;
    logic        ram_we;
    logic        ram_re;
    logic [XLEN-1:0] ram_rdata;

    assign ex_ready = (state == S_IDLE);
    assign accept   = ex_valid && ex_ready;
    // A load wins over a simultaneous store; the store is dropped.
    assign ram_re   = accept && ex.mem_r_req;
    assign ram_we   = accept && ex.mem_w_req && !ex.mem_r_req;

    lib_data_ram #(
        .W  (XLEN),
        .AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ex.mem_addr),
        .wdata (ex.x_rd),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_we  <= 1'b0;
            hold_sr  <= SR_RESET;
            sr       <= SR_RESET;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            commit   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        hold_we  <= ex.w_rd && (ex_rd != '0);
                        hold_sr  <= ex.sr;
                        rf_waddr <= ex_rd;
                        rf_wdata <= ex.x_rd;
                        if (ex.mem_r_req) begin
                            state <= S_LOAD;
                        end else begin
                            state  <= S_COMMIT;
                            commit <= 1'b1;
                            rf_we  <= ex.w_rd && (ex_rd != '0);
                        end
                    end
                end
                S_LOAD: begin
                    rf_wdata <= ram_rdata;
                    rf_we    <= hold_we;
                    commit   <= 1'b1;
                    state    <= S_COMMIT;
                end
                S_COMMIT: begin
                    sr     <= hold_sr;
                    rf_we  <= 1'b0;
                    commit <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A new request in the acknowledging commit cycle must not be lost.
    always_ff @(posedge clk) begin
        if (reset)
            intr_pending <= 1'b0;
        else if (intr_req)
            intr_pending <= 1'b1;
        else if (state == S_COMMIT && hold_sr.ack)
            intr_pending <= 1'b0;
    end

endmodule

// File: tb/tb_lib_mem_wb.sv
// Directed bench for lib_mem_wb: reset, ALU writeback, store/load, x0, load+store, interrupts, mid-load reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: drives ex_valid only while ex_ready is expected high.
module tb_lib_mem_wb;

    import lib_cpu::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    EXECUTE      ex;
    logic [3:0]  ex_rd;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    SPECIAL_REG  sr;
    logic        commit;
    logic        intr_req;
    logic        intr_pending;

    int n_checks = 0;
    int n_fail   = 0;

    lib_mem_wb dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex           (ex),
        .ex_rd        (ex_rd),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sr           (sr),
        .commit       (commit),
        .intr_req     (intr_req),
        .intr_pending (intr_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic w_rd, input logic [31:0] x_rd, input logic rreq,
                          input logic wreq, input logic [5:0] addr, input logic [31:0] pc,
                          input logic ack, input logic [3:0] rd);
        ex           = '0;
        ex.w_rd      = w_rd;
        ex.x_rd      = x_rd;
        ex.mem_r_req = rreq;
        ex.mem_w_req = wreq;
        ex.mem_addr  = addr;
        ex.sr.pc     = pc;
        ex.sr.ack    = ack;
        ex_rd        = rd;
        ex_valid     = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        ex_valid = 1'b0;
        ex       = '0;
        ex_rd    = '0;
        intr_req = 1'b0;

        // Reset
        step();
        step();
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_commit", commit, 1'b0);
        chk("rst_sr_pc", sr.pc, 32'h0);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_intr", intr_pending, 1'b0);
        chk("rst_wdata", rf_wdata, 32'h0);
        reset = 1'b0;
        step();

        // ALU result
        set_ex(1'b1, 32'h12345678, 1'b0, 1'b0, 6'd0, 32'h11, 1'b0, 4'd5);
        step();
        ex_valid = 1'b0;
        ex       = '0;
        chk("alu_commit", commit, 1'b1);
        chk("alu_rf_we", rf_we, 1'b1);
        chk("alu_waddr", rf_waddr, 4'd5);
        chk("alu_wdata", rf_wdata, 32'h12345678);
        chk("alu_busy", ex_ready, 1'b0);
        chk("alu_sr_old", sr.pc, 32'h0);
        step();
        chk("alu_commit_end", commit, 1'b0);
        chk("alu_sr_pc", sr.pc, 32'h11);
        chk("alu_ready", ex_ready, 1'b1);

        // Store to top address
        set_ex(1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 6'd63, 32'h12, 1'b0, 4'd7);
        step();
        ex_valid = 1'b0;
        chk("st_commit", commit, 1'b1);
        chk("st_rf_we", rf_we, 1'b0);
        step();

        // Load it back; x_rd garbage must be replaced
        set_ex(1'b1, 32'hAAAA5555, 1'b1, 1'b0, 6'd63, 32'h13, 1'b0, 4'd3);
        step();
        ex_valid = 1'b0;
        chk("ld_no_commit_c1", commit, 1'b0);
        chk("ld_busy_c1", ex_ready, 1'b0);
        chk("ld_no_we_c1", rf_we, 1'b0);
        step();
        chk("ld_commit", commit, 1'b1);
        chk("ld_rf_we", rf_we, 1'b1);
        chk("ld_waddr", rf_waddr, 4'd3);
        chk("ld_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("ld_sr_pc", sr.pc, 32'h13);

        // Write to x0 discarded
        set_ex(1'b1, 32'h99, 1'b0, 1'b0, 6'd0, 32'h14, 1'b0, 4'd0);
        step();
        ex_valid = 1'b0;
        chk("x0_commit", commit, 1'b1);
        chk("x0_rf_we", rf_we, 1'b0);
        step();

        // Seed RAM[4], then load+store together
        set_ex(1'b0, 32'h4444, 1'b0, 1'b1, 6'd4, 32'h15, 1'b0, 4'd0);
        step();
        ex_valid = 1'b0;
        step();
        set_ex(1'b1, 32'h55, 1'b1, 1'b1, 6'd4, 32'h16, 1'b0, 4'd6);
        step();
        ex_valid = 1'b0;
        step();
        chk("both_commit", commit, 1'b1);
        chk("both_wdata", rf_wdata, 32'h4444);
        chk("both_waddr", rf_waddr, 4'd6);
        step();
        set_ex(1'b1, 32'h0, 1'b1, 1'b0, 6'd4, 32'h17, 1'b0, 4'd2);
        step();
        ex_valid = 1'b0;
        step();
        chk("both_ram_kept", rf_wdata, 32'h4444);
        step();

        // Interrupt latch
        intr_req = 1'b1;
        step();
        intr_req = 1'b0;
        chk("intr_set", intr_pending, 1'b1);
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h20, 1'b1, 4'd0);
        step();
        ex_valid = 1'b0;
        chk("intr_ack_commit", commit, 1'b1);
        intr_req = 1'b1;
        step();
        intr_req = 1'b0;
        chk("intr_set_wins", intr_pending, 1'b1);
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h24, 1'b1, 4'd0);
        step();
        ex_valid = 1'b0;
        chk("intr_held_pre_ack", intr_pending, 1'b1);
        step();
        chk("intr_cleared", intr_pending, 1'b0);
        chk("intr_sr_pc", sr.pc, 32'h24);

        // Reset while in S_LOAD
        set_ex(1'b1, 32'h0, 1'b1, 1'b0, 6'd63, 32'h77, 1'b0, 4'd9);
        step();
        ex_valid = 1'b0;
        chk("rl_in_load", ex_ready, 1'b0);
        reset = 1'b1;
        step();
        chk("rl_commit", commit, 1'b0);
        chk("rl_rf_we", rf_we, 1'b0);
        chk("rl_sr_pc", sr.pc, 32'h0);
        reset = 1'b0;
        step();
        chk("rl_commit_after", commit, 1'b0);
        chk("rl_rf_we_after", rf_we, 1'b0);
        chk("rl_ready", ex_ready, 1'b1);

        // Store survives reset
        set_ex(1'b1, 32'h0, 1'b1, 1'b0, 6'd63, 32'h30, 1'b0, 4'd1);
        step();
        ex_valid = 1'b0;
        step();
        chk("rl_ram_kept", rf_wdata, 32'hDEADBEEF);
        chk("rl_ld_waddr", rf_waddr, 4'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lib_mem_wb.md
# lib_mem_wb

Memory/writeback stage of the CPU. It consumes one executed instruction (the EXECUTE result plus its destination index) per transaction. It performs the requested data-memory access on an internal 64 × 32-bit synchronous RAM, writes the result to the register file, and commits the next SPECIAL_REG state. It also latches external interrupt requests so that fetch can see a pending interrupt until software acknowledges it.

## Interface
Parameters:
- XLEN, 32: datapath width.
- MEM_AW, 6: data RAM address width (64 words).
- RF_AW, 4: register file index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EXECUTE result present.
- ex_ready  out  1  stage can accept.
- ex  in  EXECUTE  fields used: w_rd, x_rd, mem_r_req, mem_w_req, mem_addr, sr.
- ex_rd  in  RF_AW  destination register index.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  RF_AW  write index.
- rf_wdata  out  XLEN  write data.
- sr  out  SPECIAL_REG  committed special registers.
- commit  out  1  one-cycle pulse per retired instruction.
- intr_req  in  1  external interrupt request (level or pulse).
- intr_pending  out  1  latched, unacknowledged interrupt.

## Operation
- States: S_IDLE, S_LOAD, S_COMMIT.
- ex_ready = 1 only in S_IDLE.
- S_IDLE, on ex_valid:
  - Capture w_rd, x_rd, ex_rd, mem_r_req and sr into holding registers.
  - If mem_r_req: issue a RAM read at mem_addr and go to S_LOAD.
  - Else if mem_w_req: write x_rd to RAM[mem_addr] in this same cycle and go to S_COMMIT.
  - Else: go to S_COMMIT.
- mem_r_req and mem_w_req both set: treat as a load; the write is suppressed.
- S_LOAD: replace the held result with the RAM read data, then go to S_COMMIT.
- S_COMMIT:
  - commit = 1.
  - rf_we = held w_rd && held rd != 0, so writes to x0 are discarded.
  - rf_waddr / rf_wdata = held rd / held result.
  - sr register ← held sr.
  - Go to S_IDLE.
- Interrupt latch:
  - intr_pending is set on any cycle with intr_req = 1.
  - It is cleared in a commit cycle whose held sr.ack = 1.
  - If set and clear coincide, set wins.
- mem_addr is exactly MEM_AW bits, so wrap-around is inherent: address 63 + 1 is outside this block's concern.

## Timing
- Reset values:
  - State S_IDLE, ex_ready = 1.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - commit = 0, intr_pending = 0.
  - sr all-zero: pc = 0, intr_en = 0, intr_vec = 0, intr_pc = 0, ack = 0, tx_req = 0, tx_data = 0.
- RAM contents are not reset.
- Latency from the accept edge (cycle 0) to commit:
  - Non-load: commit high in cycle 1; new sr visible from cycle 2.
  - Load: commit high in cycle 2.
- Throughput: one instruction per 2 cycles (non-load) or 3 cycles (load).
- rf_we, rf_waddr, rf_wdata and commit are registered outputs, valid in the S_COMMIT cycle.
- sr is registered and updates on the edge ending S_COMMIT.
- RAM read latency is 1 cycle. A store's data is readable by a load accepted in any later cycle.
- ex inputs are sampled only on the accept edge; they may change freely otherwise.
- Reset asserted in S_LOAD or S_COMMIT:
  - The in-flight instruction is dropped: no commit, no rf write, sr returns to reset values.
  - A store already written in its accept cycle remains in RAM.

## Structure
- Shared package lib_mem, importing lib_cpu:
  - MEM_STATE enum (S_IDLE, S_LOAD, S_COMMIT).
  - MEM_WORDS = 64.
  - Reset constant SR_RESET of type SPECIAL_REG.
- EXECUTE and SPECIAL_REG types remain in lib_cpu.
- One sub-module, lib_data_ram: single-port 64 × 32, synchronous write, registered read, inferred block RAM.

## Test plan
- Reset: assert reset 2 cycles -> rf_we = 0, commit = 0, sr.pc = 0, ex_ready = 1, intr_pending = 0.
- ALU result: ex w_rd = 1, rd = 5, x_rd = 0x12345678, sr.pc = 0x11 -> commit with rf_we = 1, rf_waddr = 5, rf_wdata = 0x12345678 one cycle after accept; sr.pc = 0x11 the following cycle.
- Store then load:
  - Store: mem_w_req, mem_addr = 63, x_rd = 0xDEADBEEF.
  - Load: mem_r_req, mem_addr = 63, rd = 3.
  - Expected: the load commits 2 cycles after its accept with rf_wdata = 0xDEADBEEF; the store commits with rf_we = 0.
- Write to x0 / both requests:
  - rd = 0 with w_rd = 1 -> rf_we = 0, commit = 1.
  - mem_r_req = mem_w_req = 1 at addr 4, x_rd = 0x55 -> returns the old RAM[4], which is left unchanged.
- Interrupt latch:
  - intr_req pulse -> intr_pending = 1 next cycle.
  - Commit with sr.ack = 1 and concurrent intr_req -> intr_pending stays 1.
  - Next ack commit without intr_req -> intr_pending = 0.
- Reset mid-load: accept a load, assert reset in S_LOAD -> no commit, no rf_we, ex_ready = 1 after reset deasserts.
